// File: rtl/fetch_unit.sv
// Program-counter and instruction-fetch stage: issues req/ack reads to instruction memory,
// latches the returned word for the decoder and traps misaligned targets and memory timeouts.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    input  logic            instr_done,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [6:0]      op,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_valid,
    output logic            misaligned,
    output logic            timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    // Last wait count before giving up; an ack in that same cycle still wins.
    localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t          state_r, state_next_s;
    logic [XLEN-1:0] pc_r, pc_next_s;
    logic [31:0]     instr_r, instr_next_s;
    logic [7:0]      wait_cnt_r, wait_cnt_next_s;
    logic            req_r, req_next_s;
    logic            valid_r, valid_next_s;
    logic            misaligned_r, misaligned_next_s;
    logic            timeout_r, timeout_next_s;

    // Next-state, datapath and sticky-flag logic for the fetch FSM.
    always_comb begin
        state_next_s      = state_r;
        pc_next_s         = pc_r;
        instr_next_s      = instr_r;
        wait_cnt_next_s   = wait_cnt_r;
        valid_next_s      = valid_r;
        misaligned_next_s = misaligned_r;
        timeout_next_s    = timeout_r;
        case (state_r)
            IDLE: begin
                state_next_s = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_next_s    = imem_rdata;
                    valid_next_s    = 1'b1;
                    wait_cnt_next_s = 8'd0;
                    state_next_s    = EXEC;
                end else if (wait_cnt_r >= WAIT_LAST) begin
                    timeout_next_s  = 1'b1;
                    wait_cnt_next_s = 8'd0;
                    state_next_s    = HALT;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + 8'd1;
                end
            end
            EXEC: begin
                if (instr_done) begin
                    valid_next_s = 1'b0;
                    if (!pc_src) begin
                        pc_next_s    = pc_r + XLEN'(4);
                        state_next_s = FETCH;
                    end else if (pc_target[1:0] == 2'b00) begin
                        pc_next_s    = pc_target;
                        state_next_s = FETCH;
                    end else begin
                        misaligned_next_s = 1'b1;
                        state_next_s      = HALT;
                    end
                end else begin
                    state_next_s = EXEC;
                end
            end
            HALT: begin
                valid_next_s = 1'b0;
                state_next_s = HALT;
            end
            default: begin
                valid_next_s = 1'b0;
                state_next_s = HALT;
            end
        endcase
        // Request is registered so it rises on the edge that enters FETCH.
        req_next_s = (state_next_s == FETCH);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            instr_r      <= NOP_INSTR;
            wait_cnt_r   <= 8'd0;
            req_r        <= 1'b0;
            valid_r      <= 1'b0;
            misaligned_r <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            pc_r         <= pc_next_s;
            instr_r      <= instr_next_s;
            wait_cnt_r   <= wait_cnt_next_s;
            req_r        <= req_next_s;
            valid_r      <= valid_next_s;
            misaligned_r <= misaligned_next_s;
            timeout_r    <= timeout_next_s;
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign op          = instr_r[6:0];
    assign pc          = pc_r;
    assign pc_plus4    = pc_r + XLEN'(4);
    assign instr_valid = valid_r;
    assign misaligned  = misaligned_r;
    assign timeout     = timeout_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven fetch/execute vectors with a scoreboard
// of expected fetch addresses, plus hand sequences for misalignment, timeout and reset.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        instr_done;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        imem_req, instr_valid, misaligned, timeout;
    logic [31:0] imem_addr, instr, pc, pc_plus4;
    logic [6:0]  op;

    logic        w_req, w_valid, w_mis, w_to;
    logic [31:0] w_addr, w_instr, w_pc, w_plus4;
    logic [6:0]  w_op;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .pc_target(pc_target),
        .instr_done(instr_done), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .op(op),
        .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
        .misaligned(misaligned), .timeout(timeout)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .pc_target(pc_target),
        .instr_done(instr_done), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(w_instr), .op(w_op),
        .pc(w_pc), .pc_plus4(w_plus4), .instr_valid(w_valid),
        .misaligned(w_mis), .timeout(w_to)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          delay;
        logic [31:0] rdata;
        logic        src;
        logic [31:0] tgt;
        logic [6:0]  exp_op;
        logic [31:0] exp_plus4;
    } vec_t;

    vec_t        tv [8];
    logic [31:0] exp_q [$];
    logic [31:0] model_pc;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; pc_src = 1'b0; pc_target = 32'h0; instr_done = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_flags", {30'd0, misaligned, timeout}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_op", {25'd0, op}, 32'h13);
        exp_q.delete();
        model_pc = 32'h0;
        exp_q.push_back(model_pc);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait for a request, hold it for 'delay' cycles, then acknowledge.
    task automatic fetch_one(input int delay, input logic [31:0] rdata,
                             input logic [6:0] exp_op, input logic [31:0] exp_plus4);
        int          n;
        logic        stable;
        logic [31:0] exp_addr;
        n = 0;
        while (!imem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            chk("req_wait", {31'd0, imem_req}, 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        exp_addr = exp_q.pop_front();
        chk("fetch_addr", imem_addr, exp_addr);
        stable = 1'b1;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (!imem_req || imem_addr !== exp_addr || instr_valid) stable = 1'b0;
        end
        chk("req_stable", {31'd0, stable}, 32'd1);
        imem_ack = 1'b1;
        imem_rdata = rdata;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("valid", {31'd0, instr_valid}, 32'd1);
        chk("instr", instr, rdata);
        chk("op", {25'd0, op}, {25'd0, exp_op});
        chk("pc", pc, exp_addr);
        chk("pc_plus4", pc_plus4, exp_plus4);
        chk("req_low_exec", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic exec_done(input logic src, input logic [31:0] tgt);
        logic halt;
        halt = src && (tgt[1:0] != 2'b00);
        if (!halt) begin
            model_pc = src ? tgt : model_pc + 32'd4;
            exp_q.push_back(model_pc);
        end
        instr_done = 1'b1; pc_src = src; pc_target = tgt;
        @(negedge clk);
        instr_done = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
        chk("valid_drop", {31'd0, instr_valid}, 32'd0);
        if (halt) begin
            chk("misaligned", {31'd0, misaligned}, 32'd1);
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_pc", pc, model_pc);
        end else begin
            chk("next_req", {31'd0, imem_req}, 32'd1);
        end
    endtask

    initial begin
        tv[0] = '{1, 32'h0050_0093, 1'b0, 32'h0,         7'h13, 32'h4};
        tv[1] = '{0, 32'h0010_0113, 1'b0, 32'h0,         7'h13, 32'h8};
        tv[2] = '{2, 32'h0020_8193, 1'b0, 32'h0,         7'h13, 32'hC};
        tv[3] = '{3, 32'hFE00_0EE3, 1'b1, 32'h8,         7'h63, 32'h10};
        tv[4] = '{0, 32'h0000_006F, 1'b1, 32'h40,        7'h6F, 32'hC};
        tv[5] = '{1, 32'h0000_0037, 1'b1, 32'hFFFF_FFFC, 7'h37, 32'h44};
        tv[6] = '{2, 32'h0000_0017, 1'b0, 32'h0,         7'h17, 32'h0};
        tv[7] = '{0, 32'h0000_0013, 1'b0, 32'h0,         7'h13, 32'h4};

        rst_n = 1'b0;
        do_reset();
        for (int v = 0; v < 8; v++) begin
            fetch_one(tv[v].delay, tv[v].rdata, tv[v].exp_op, tv[v].exp_plus4);
            exec_done(tv[v].src, tv[v].tgt);
        end

        // Misaligned taken target halts with pc held; later acks are ignored.
        fetch_one(0, 32'h0000_0063, 7'h63, 32'h8);
        exec_done(1'b1, 32'h42);
        imem_ack = 1'b1;
        instr_done = 1'b1;
        repeat (4) @(negedge clk);
        imem_ack = 1'b0;
        instr_done = 1'b0;
        chk("halt_sticky_req", {31'd0, imem_req}, 32'd0);
        chk("halt_sticky_valid", {31'd0, instr_valid}, 32'd0);
        chk("halt_sticky_pc", pc, 32'h4);
        chk("halt_sticky_mis", {31'd0, misaligned}, 32'd1);
        chk("halt_no_timeout", {31'd0, timeout}, 32'd0);

        // Ack on the last allowed cycle wins; a fully withheld ack times out.
        do_reset();
        fetch_one(14, 32'h0000_0093, 7'h13, 32'h4);
        chk("late_ack_timeout", {31'd0, timeout}, 32'd0);
        exec_done(1'b0, 32'h0);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 14) begin
                chk("to_before_req", {31'd0, imem_req}, 32'd1);
                chk("to_before_flag", {31'd0, timeout}, 32'd0);
            end
        end
        @(negedge clk);
        chk("timeout_flag", {31'd0, timeout}, 32'd1);
        chk("timeout_req", {31'd0, imem_req}, 32'd0);
        chk("timeout_valid", {31'd0, instr_valid}, 32'd0);
        repeat (3) @(negedge clk);
        chk("timeout_sticky", {31'd0, timeout}, 32'd1);

        // Asynchronous reset while a request is outstanding.
        do_reset();
        repeat (2) @(negedge clk);
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, imem_req}, 32'd0);
        chk("async_rst_wrap_addr", w_addr, 32'hFFFF_FFFC);

        // Wrap-around of pc+4 on the instance booting at the top word.
        do_reset();
        fetch_one(0, 32'h0000_0013, 7'h13, 32'h4);
        chk("wrap_plus4", w_plus4, 32'h0);
        exec_done(1'b0, 32'h0);
        chk("wrap_req", {31'd0, w_req}, 32'd1);
        chk("wrap_addr", w_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
